// File: rtl/tick_prescaler_if.sv
// Button inputs and tick/status outputs of the tick prescaler.
// The master drives the buttons. The slave is the prescaler.
interface tick_prescaler_if;
    logic btn_run;
    logic btn_step;
    logic tick;
    logic running;
    logic step_ack;

    modport master (
        output btn_run,
        output btn_step,
        input  tick,
        input  running,
        input  step_ack
    );

    modport slave (
        input  btn_run,
        input  btn_step,
        output tick,
        output running,
        output step_ack
    );
endinterface

// File: rtl/tick_prescaler.sv
// Divides the board clock into a one-cycle tick enable.
// Two debounced buttons select run/pause and single-step.
module tick_prescaler #(
    parameter int unsigned CLK_HZ          = 12000000,
    parameter int unsigned TICK_HZ         = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
    input  logic              clock,
    input  logic              reset_n,
    tick_prescaler_if.slave   bus
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("tick_prescaler: CLK_HZ/TICK_HZ must be at least 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
            $error("tick_prescaler: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic {
        PAUSED = 1'b0,
        RUN    = 1'b1
    } state_e;

    // Bit 0 of each pair is the run button and bit 1 is the step button.
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      stable_q, stable_d, stable_prev_q;
    logic [1:0]      press_q, press_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             running_q, running_d;
    logic             step_ack_q, step_ack_d;

    // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            stable_d[b] = stable_q[b];
            db_cnt_d[b] = '0;
            if (sync2_q[b] != stable_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    stable_d[b] = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
                end
            end
        end
        press_d = stable_q & ~stable_prev_q;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        tick_d     = 1'b0;
        step_ack_d = 1'b0;
        case (state_q)
            PAUSED: begin
                count_d = '0;
                if (press_q[0]) begin
                    state_d = RUN;
                end else if (press_q[1]) begin
                    tick_d     = 1'b1;
                    step_ack_d = 1'b1;
                end
            end
            RUN: begin
                if (press_q[0]) begin
                    state_d = PAUSED;
                    count_d = '0;
                end else begin
                    tick_d  = (count_q == CNT_LAST);
                    count_d = (count_q == CNT_LAST) ? '0 : count_q + CNT_W'(1);
                end
            end
        endcase
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            press_q       <= '0;
            db_cnt_q[0]   <= '0;
            db_cnt_q[1]   <= '0;
            state_q       <= PAUSED;
            count_q       <= '0;
            tick_q        <= 1'b0;
            running_q     <= 1'b0;
            step_ack_q    <= 1'b0;
        end else begin
            sync1_q       <= {bus.btn_step, bus.btn_run};
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= press_d;
            db_cnt_q[0]   <= db_cnt_d[0];
            db_cnt_q[1]   <= db_cnt_d[1];
            state_q       <= state_d;
            count_q       <= count_d;
            tick_q        <= tick_d;
            running_q     <= running_d;
            step_ack_q    <= step_ack_d;
        end
    end

    assign bus.tick     = tick_q;
    assign bus.running  = running_q;
    assign bus.step_ack = step_ack_q;

endmodule

// File: tb/tb_tick_prescaler.sv
// Bench for tick_prescaler with CLK_HZ=10, TICK_HZ=2 (DIV=5) and DEBOUNCE_CYCLES=4.
// Each cycle is compared against a sample-window and timestamp model.
module tb_tick_prescaler;

    localparam int DIV = 5;
    localparam int DB  = 4;

    logic clock;
    logic reset_n;
    tick_prescaler_if bus ();

    tick_prescaler #(
        .CLK_HZ          (10),
        .TICK_HZ         (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int obs_ticks, obs_acks, first_tick, rise, kcyc;

    // Model state: the raw samples in the 2-flop pipeline, the last DB synchronised samples,
    // the accepted levels, the presses and the time RUN was entered.
    bit [1:0] rq [$];
    bit [1:0] wq [$];
    bit [1:0] m_stable, m_prev, m_press;
    bit       m_run, m_tick, m_ack;
    int       mcyc = 0;
    int       m_tstart = 0;

    function automatic void model_reset();
        rq = '{2'b00, 2'b00};
        wq.delete();
        m_stable = '0;
        m_prev   = '0;
        m_press  = '0;
        m_run    = 1'b0;
        m_tick   = 1'b0;
        m_ack    = 1'b0;
    endfunction

    function automatic void model_step(bit run_raw, bit step_raw);
        bit [1:0] s;
        bit       all_diff;
        mcyc++;
        if (m_press[0]) begin
            m_run    = !m_run;
            m_tstart = mcyc;
            m_tick   = 1'b0;
            m_ack    = 1'b0;
        end else if (m_press[1] && !m_run) begin
            m_tick = 1'b1;
            m_ack  = 1'b1;
        end else begin
            m_ack  = 1'b0;
            m_tick = m_run && (((mcyc - m_tstart) % DIV) == 0);
        end
        m_press = m_stable & ~m_prev;
        m_prev  = m_stable;
        rq.push_back({step_raw, run_raw});
        s = rq.pop_front();
        wq.push_back(s);
        if (wq.size() > DB) void'(wq.pop_front());
        if (wq.size() == DB) begin
            for (int b = 0; b < 2; b++) begin
                all_diff = 1'b1;
                foreach (wq[i]) if (wq[i][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) m_stable[b] = ~m_stable[b];
            end
        end
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_obs();
        obs_ticks  = 0;
        obs_acks   = 0;
        first_tick = -1;
        rise       = -1;
        kcyc       = 0;
    endtask

    // One clock edge: advance the model, then compare all outputs 1 time unit later.
    task automatic step_cycle();
        @(posedge clock);
        if (!reset_n) model_reset();
        else model_step(bus.btn_run, bus.btn_step);
        #1;
        chk("tick", bus.tick, m_tick);
        chk("running", bus.running, m_run);
        chk("step_ack", bus.step_ack, m_ack);
        if (bus.tick === 1'b1) begin
            obs_ticks++;
            if (first_tick < 0) first_tick = kcyc;
        end
        if (bus.step_ack === 1'b1) obs_acks++;
        if (rise < 0 && bus.running === 1'b1) rise = kcyc;
        kcyc++;
    endtask

    initial begin
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        reset_n      = 1'b0;
        model_reset();
        clear_obs();
        repeat (3) step_cycle();
        #4 reset_n = 1'b1;

        // Idle after reset.
        clear_obs();
        repeat (50) step_cycle();
        chk_int("idle_ticks", obs_ticks, 0);
        chk_int("idle_acks", obs_acks, 0);

        // A 3-cycle glitch on btn_run is rejected.
        bus.btn_run = 1'b1;
        repeat (3) step_cycle();
        bus.btn_run = 1'b0;
        repeat (12) step_cycle();
        chk("glitch_running", bus.running, 1'b0);
        chk_int("glitch_dbcnt", int'(dut.db_cnt_q[0]), 0);

        // Three step presses while paused.
        clear_obs();
        repeat (3) begin
            bus.btn_step = 1'b1;
            repeat (10) step_cycle();
            bus.btn_step = 1'b0;
            repeat (10) step_cycle();
        end
        chk_int("step_ticks", obs_ticks, 3);
        chk_int("step_acks", obs_acks, 3);
        chk("step_running", bus.running, 1'b0);

        // Hold btn_run: running at cycle 7, ticks at 12, 17, 22, 27.
        clear_obs();
        bus.btn_run = 1'b1;
        repeat (30) step_cycle();
        chk_int("run_rise", rise, 7);
        chk_int("run_first_tick", first_tick, 12);
        chk_int("run_ticks", obs_ticks, 4);
        bus.btn_run = 1'b0;
        repeat (10) step_cycle();

        // Step presses while running are ignored.
        clear_obs();
        bus.btn_step = 1'b1;
        repeat (10) step_cycle();
        bus.btn_step = 1'b0;
        repeat (10) step_cycle();
        chk_int("runstep_acks", obs_acks, 0);
        chk_int("runstep_ticks", obs_ticks, 4);

        // Align the pause press so that it lands on a tick-due cycle.
        for (int i = 0; i < DIV; i++) begin
            if (((mcyc + 8 - m_tstart) % DIV) == 0) break;
            step_cycle();
        end
        bus.btn_run = 1'b1;
        repeat (8) step_cycle();
        chk("pause_running", bus.running, 1'b0);
        chk("pause_tick_suppressed", bus.tick, 1'b0);
        bus.btn_run = 1'b0;
        clear_obs();
        repeat (20) step_cycle();
        chk_int("paused_ticks", obs_ticks, 0);

        // Asynchronous reset mid-run with btn_run held.
        bus.btn_run = 1'b1;
        repeat (12) step_cycle();
        chk("pre_reset_running", bus.running, 1'b1);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_tick", bus.tick, 1'b0);
        chk("async_running", bus.running, 1'b0);
        chk("async_step_ack", bus.step_ack, 1'b0);
        chk_int("async_state", int'(dut.state_q), 0);
        step_cycle();
        #4 reset_n = 1'b1;
        clear_obs();
        repeat (12) step_cycle();
        chk_int("rereset_rise", rise, 7);
        bus.btn_run = 1'b0;
        repeat (10) step_cycle();

        // Random button activity.
        repeat (40) begin
            bus.btn_run  = ($urandom_range(0, 3) == 0);
            bus.btn_step = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 12)) step_cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tick_prescaler.md
Name: tick_prescaler

Overview:
- Upstream stage of the two-bit flip-flop counter on the Vaman FPGA board.
- Divides the fast board clock into a one-cycle `tick` enable pulse.
- The counter advances only on `tick`, so its LEDs change at a human-visible rate.
- Two raw push buttons, synchronised and debounced here, select free-run/pause and single-step.

Parameters:
- CLK_HZ, 12000000, board clock frequency in Hz.
- TICK_HZ, 2, free-run tick rate in Hz. DIV = CLK_HZ/TICK_HZ (integer division). DIV >= 2 required; elaboration error otherwise.
- DEBOUNCE_CYCLES, 240000, consecutive stable synchronised samples required to accept a button level change. Must be >= 1.

Ports:
- clock  in  1  board clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- btn_run  in  1  raw asynchronous button, active-high; each press toggles run/pause.
- btn_step  in  1  raw asynchronous button, active-high; each press emits one tick while paused.
- tick  out  1  registered one-cycle enable pulse to the counter stage.
- running  out  1  registered; 1 in RUN state.
- step_ack  out  1  registered one-cycle pulse, coincident with a step-generated tick.

Behaviour:
- Reset (reset_n low, asynchronous):
  - tick=0, running=0, step_ack=0, state=PAUSED, prescale count=0.
  - Synchroniser flops and debounced levels=0, debounce counters=0.
  - Takes effect immediately, including mid-count or mid-debounce. No tick is emitted on release.
- Synchronisation: each button passes through a 2-flop synchroniser; its output is s.
- Debounce (per button):
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - If s == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= s, counter <= 0.
  - Else: counter++.
  - Any glitch shorter than DEBOUNCE_CYCLES samples leaves stable unchanged.
- Press detect: press is a registered pulse, 1 for exactly one cycle after stable rises 0->1. Releases generate nothing.
- Fixed latency: from the first clock edge sampling a new held raw level to press high is 2+DEBOUNCE_CYCLES cycles.
- FSM states: PAUSED, RUN.
  - PAUSED + run_press -> RUN; prescale count <= 0; running=1 from next cycle.
  - RUN + run_press -> PAUSED; prescale count <= 0; running=0 from next cycle. A tick due in that same cycle is suppressed.
  - PAUSED + step_press (no run_press) -> tick=1 and step_ack=1 next cycle, for one cycle. State is unchanged.
  - RUN + step_press -> ignored; step_ack stays 0.
  - run_press and step_press in the same cycle -> run_press wins; step is discarded.
- Prescaler (RUN only):
  - Count width $clog2(DIV); counts 0..DIV-1, wraps to 0.
  - tick=1 in the cycle after count == DIV-1, giving exactly one tick every DIV cycles.
  - First tick after entering RUN arrives DIV cycles after running rises.
  - In PAUSED the count holds at 0.
- tick is never high in two consecutive cycles (DIV >= 2; step ticks are separated by the debounce latency).

Test Plan:
(All scenarios use CLK_HZ=10, TICK_HZ=2, giving DIV=5, and DEBOUNCE_CYCLES=4.)
- Reset, buttons low, 50 cycles -> tick=0, running=0, step_ack=0 throughout.
- btn_run held high from cycle 0 -> running rises at cycle 7 (2 sync + 4 debounce + 1 FSM). Ticks at cycles 12, 17, 22, ...; exactly one-cycle pulses, period 5.
- btn_run pulsed for 3 cycles only (glitch) -> running stays 0; debounce counter returns to 0.
- Paused; btn_step held 10 cycles, then released for 10 cycles, three times -> exactly three single-cycle ticks, each with step_ack=1; running stays 0.
- Running; btn_step pressed -> no extra tick, step_ack=0, tick period unchanged at 5. Second btn_run press -> running falls; no further ticks; a tick due in the pause cycle is absent.
- Mid-run, reset_n low for 1 cycle asynchronously between edges -> outputs 0 immediately, state=PAUSED. Button still held afterwards re-debounces: running rises 7 cycles after release.
